timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameters: none; register offsets and widths are fixed by this document.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Addr  input  30  word address, Addr[31:2] from the address decoder; only Addr[3:2] is decoded.
REQ-005 WE  input  1  write enable, already qualified by the decoder's timer-window match.
REQ-006 Din  input  32  write data.
REQ-007 Dout  output  32  read data, combinational from current register state.
REQ-008 IRQ  output  1  interrupt request, level, registered source; connected to HWInt bit 0 (timer 1) or bit 1 (timer 2).

Function
REQ-009 Register map by Addr[3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
REQ-010 Reserved offset: reads 0; writes ignored.
REQ-011 CTRL fields:
- bit0 EN (enable)
- bits2:1 MODE (00 = one-shot; 01 = auto-reload; 10/11 = one-shot)
- bit3 IM (interrupt mask, 1 = allow)
- bits31:4 read 0, writes ignored.
REQ-012 PRESET: 32-bit, read/write.
REQ-013 COUNT: 32-bit, read-only; writes to it are ignored.
REQ-014 Dout = selected register per REQ-009, with no read side effects.
REQ-015 FSM states IDLE, LOAD, CNT, INT; the state and all registers update only on the clk edge.
REQ-016 IDLE: EN=1 -> LOAD; otherwise stay in IDLE; COUNT holds.
REQ-017 LOAD: COUNT <= PRESET; -> CNT, regardless of EN.
REQ-018 CNT transitions:
- EN=0 -> IDLE, COUNT holds.
- EN=1 and COUNT>1 -> COUNT-1, stay in CNT.
- EN=1 and COUNT<=1 -> COUNT <= 0, FLAG <= 1, -> INT.
REQ-019 INT, one-shot mode: EN <= 0; -> IDLE; FLAG stays 1.
REQ-020 INT, auto-reload mode: -> LOAD; FLAG <= 0, so FLAG is a one-cycle pulse.
REQ-021 IRQ = FLAG & IM, driven from registers with no combinational path from Din.
REQ-022 In one-shot mode, FLAG clears on any write to CTRL or PRESET.
REQ-023 Write decoding: a write to PRESET takes effect at the next LOAD only; a count in progress is not affected.
REQ-024 CTRL write in the same cycle as INT's EN clear: the written value wins.
REQ-025 CTRL write while in CNT: the new EN/MODE are seen by the FSM on the following cycle.
REQ-026 Latency: after the edge that writes EN=1 from IDLE with PRESET=N (N>=1), FLAG rises at edge N+2.
REQ-027 PRESET=0 behaves as PRESET=1: FLAG rises at edge 3.
REQ-028 Decrement never wraps: COUNT never goes below 0, and 32'hFFFFFFFF counts down normally.

Reset
REQ-029 When reset is high at a clk edge: CTRL=0, PRESET=0, COUNT=0, FLAG=0, state=IDLE, so IRQ=0 and Dout reads 0 for every offset.
REQ-030 Reset overrides any concurrent write and any FSM transition.
REQ-031 Reset mid-count aborts the count with no IRQ.
REQ-032 After reset is released, the block is idle until CTRL.EN is written 1.

Verification
REQ-033 One-shot: PRESET=5, CTRL=4'b1001 -> COUNT reads 5,4,3,2,1,0 on successive cycles after LOAD; IRQ=1 at edge 7 after the CTRL write and stays high; CTRL reads 4'b1000; a write of CTRL=0 clears IRQ on the next cycle.
REQ-034 Auto-reload: PRESET=3, CTRL=4'b1011 -> IRQ pulses high for exactly 1 cycle every 5 cycles; COUNT sequence 3,2,1,0,(0),3,...
REQ-035 Mask: PRESET=2, CTRL=4'b0001 -> FLAG sets and IRQ stays 0; a later CTRL=4'b1000 write clears FLAG, and IRQ stays 0.
REQ-036 Disable mid-count: PRESET=100, enable, then write CTRL=0 after 10 cycles -> COUNT freezes near 91; no IRQ; re-enable reloads COUNT to 100.
REQ-037 Register edges: a write to COUNT or offset 3 -> no change, and offset 3 reads 0; CTRL write 32'hFFFFFFFF reads back 32'h0000000F; PRESET=0 -> IRQ at edge 3.
REQ-038 Reset during CNT with COUNT=40 -> all registers read 0 and IRQ=0 the next cycle; no spurious IRQ afterwards.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) raising a level IRQ in one-shot or auto-reload mode.
// Reads are combinational from register state; every state change happens on the rising clk edge.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] count_nxt;
  logic        flag;
  logic        flag_nxt;
  logic        en_clr;

  logic [1:0]  offset;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic        auto_reload;
  logic        im;
  logic        unused_addr;

  assign offset      = Addr[1:0];
  assign unused_addr = ^Addr[29:2];
  assign wr_ctrl     = WE && (offset == 2'd0);
  assign wr_preset   = WE && (offset == 2'd1);
  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign im          = ctrl[3];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    // In one-shot mode any CTRL/PRESET write acknowledges a pending flag.
    flag_nxt  = flag & ~((wr_ctrl | wr_preset) & ~auto_reload);
    en_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt = 32'd0;
          flag_nxt  = 1'b1;
          state_nxt = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          flag_nxt  = 1'b0;
          state_nxt = LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ctrl   <= 4'd0;
      preset <= 32'd0;
      count  <= 32'd0;
      flag   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      flag  <= flag_nxt;
      // A software CTRL write takes priority over the one-shot auto-disable.
      if (wr_ctrl) begin
        ctrl <= Din[3:0];
      end else if (en_clr) begin
        ctrl[0] <= 1'b0;
      end
      if (wr_preset) preset <= Din;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (offset)
      2'd0:    Dout = {28'd0, ctrl};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = flag & im;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios against hand-derived values plus random traffic
// checked against a cycle-level behavioural model of the register/timer rules.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 reload pending, 2 counting, 3 expired.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_phase;

  task automatic model_step(input logic r, input logic we, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  c;
    logic [31:0] p;
    logic [31:0] n;
    logic        f;
    int          ph;
    bit          fired;
    bit          reload;
    if (r) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = 0;
    end else begin
      c = m_ctrl; p = m_preset; n = m_count; f = m_flag; ph = m_phase; fired = 0;
      reload = (m_ctrl[2:1] == 2'b01);
      if (m_phase == 0) begin
        if (m_ctrl[0]) ph = 1;
      end else if (m_phase == 1) begin
        n = m_preset; ph = 2;
      end else if (m_phase == 2) begin
        if (!m_ctrl[0]) ph = 0;
        else if (m_count > 1) n = m_count - 1;
        else begin n = 0; f = 1; fired = 1; ph = 3; end
      end else begin
        if (reload) begin f = 0; ph = 1; end
        else begin c[0] = 1'b0; ph = 0; end
      end
      if (we && (a <= 2'd1) && !reload && !fired) f = 0;
      if (we && a == 2'd0) c = d[3:0];
      if (we && a == 2'd1) p = d;
      m_ctrl = c; m_preset = p; m_count = n; m_flag = f; m_phase = ph;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: drive inputs, take the edge, advance model, return just after the falling edge.
  task automatic tick(input logic r, input logic we, input logic [1:0] a, input logic [31:0] d);
    reset = r; WE = we; Addr = {28'($urandom), a}; Din = d;
    @(posedge clk);
    model_step(r, we, a, d);
    @(negedge clk);
    reset = 1'b0; WE = 1'b0; Din = 32'd0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    Addr = {28'($urandom), a};
    #1;
    v = Dout;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    tick(1'b1, 1'b1, 2'd0, 32'hF);
    for (int a = 0; a < 4; a++) begin
      peek(a[1:0], v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL reset_dout[%0d] got=%h exp=0", a, v); end
    end
    total++;
    if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
    for (int e = 0; e < 4; e++) tick(1'b0, 1'b0, 2'd0, 32'd0);
    peek(2'd2, v);
    total++;
    if (v !== 32'd0) begin bad++; $display("FAIL reset_idle_count got=%h exp=0", v); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    logic [31:0] exp;
    tick(1'b0, 1'b1, 2'd1, 32'd5);
    tick(1'b0, 1'b1, 2'd0, 32'h9);
    for (int e = 1; e <= 9; e++) begin
      tick(1'b0, 1'b0, 2'd0, 32'd0);
      peek(2'd2, v);
      exp = (e >= 2 && e <= 7) ? 32'(7 - e) : 32'd0;
      total++;
      if (v !== exp) begin bad++; $display("FAIL oneshot_count edge=%0d got=%0d exp=%0d", e, v, exp); end
      total++;
      if (IRQ !== (e >= 7)) begin bad++; $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", e, IRQ, e >= 7); end
    end
    peek(2'd0, v);
    total++;
    if (v !== 32'h8) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=8", v); end
    tick(1'b0, 1'b1, 2'd0, 32'd0);
    total++;
    if (IRQ !== 1'b0) begin bad++; $display("FAIL oneshot_irq_clear got=%b exp=0", IRQ); end
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    logic [31:0] exp;
    int          k;
    int          pulses;
    pulses = 0;
    tick(1'b0, 1'b1, 2'd1, 32'd3);
    tick(1'b0, 1'b1, 2'd0, 32'hB);
    for (int e = 1; e <= 22; e++) begin
      tick(1'b0, 1'b0, 2'd0, 32'd0);
      peek(2'd2, v);
      k = (e - 2) % 5;
      exp = (e < 2) ? 32'd0 : ((k < 4) ? 32'(3 - k) : 32'd0);
      total++;
      if (v !== exp) begin bad++; $display("FAIL reload_count edge=%0d got=%0d exp=%0d", e, v, exp); end
      total++;
      if (IRQ !== (e >= 5 && (e - 5) % 5 == 0)) begin
        bad++; $display("FAIL reload_irq edge=%0d got=%b", e, IRQ);
      end
      if (IRQ === 1'b1) pulses++;
    end
    total++;
    if (pulses != 4) begin bad++; $display("FAIL reload_pulses got=%0d exp=4", pulses); end
    tick(1'b0, 1'b1, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic test_mask();
    tick(1'b0, 1'b1, 2'd1, 32'd2);
    tick(1'b0, 1'b1, 2'd0, 32'h1);
    for (int e = 1; e <= 8; e++) begin
      tick(1'b0, 1'b0, 2'd0, 32'd0);
      total++;
      if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_irq edge=%0d got=%b exp=0", e, IRQ); end
    end
    tick(1'b0, 1'b1, 2'd0, 32'h8);
    for (int e = 0; e < 4; e++) begin
      total++;
      if (IRQ !== 1'b0) begin bad++; $display("FAIL mask_unmask_irq cyc=%0d got=%b exp=0", e, IRQ); end
      tick(1'b0, 1'b0, 2'd0, 32'd0);
    end
    tick(1'b0, 1'b1, 2'd0, 32'd0);
  endtask

  task automatic test_disable();
    logic [31:0] v;
    tick(1'b0, 1'b1, 2'd1, 32'd100);
    tick(1'b0, 1'b1, 2'd0, 32'h9);
    for (int e = 1; e <= 10; e++) tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b1, 2'd0, 32'd0);
    for (int e = 0; e < 5; e++) begin
      tick(1'b0, 1'b0, 2'd0, 32'd0);
      peek(2'd2, v);
      total++;
      if (v !== 32'd91) begin bad++; $display("FAIL disable_freeze cyc=%0d got=%0d exp=91", e, v); end
      total++;
      if (IRQ !== 1'b0) begin bad++; $display("FAIL disable_irq cyc=%0d got=%b exp=0", e, IRQ); end
    end
    tick(1'b0, 1'b1, 2'd0, 32'h1);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    peek(2'd2, v);
    total++;
    if (v !== 32'd100) begin bad++; $display("FAIL disable_reload got=%0d exp=100", v); end
    tick(1'b0, 1'b1, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic test_reg_edges();
    logic [31:0] v;
    tick(1'b0, 1'b1, 2'd2, 32'h1234);
    peek(2'd2, v);
    total++;
    if (v !== 32'd99) begin bad++; $display("FAIL count_write_ignored got=%h exp=63", v); end
    tick(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF);
    peek(2'd3, v);
    total++;
    if (v !== 32'd0) begin bad++; $display("FAIL reserved_read got=%h exp=0", v); end
    peek(2'd1, v);
    total++;
    if (v !== 32'd100) begin bad++; $display("FAIL reserved_write_preset got=%0d exp=100", v); end
    peek(2'd0, v);
    total++;
    if (v !== 32'd0) begin bad++; $display("FAIL reserved_write_ctrl got=%h exp=0", v); end
    tick(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF);
    peek(2'd0, v);
    total++;
    if (v !== 32'h0000_000F) begin bad++; $display("FAIL ctrl_width got=%h exp=0000000f", v); end
    tick(1'b0, 1'b1, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b1, 2'd1, 32'd0);
    tick(1'b0, 1'b1, 2'd0, 32'h9);
    for (int e = 1; e <= 3; e++) begin
      tick(1'b0, 1'b0, 2'd0, 32'd0);
      total++;
      if (IRQ !== (e == 3)) begin bad++; $display("FAIL preset0_irq edge=%0d got=%b exp=%b", e, IRQ, e == 3); end
    end
    tick(1'b0, 1'b1, 2'd0, 32'd0);
    tick(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF);
    tick(1'b0, 1'b1, 2'd0, 32'h1);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    peek(2'd2, v);
    total++;
    if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL max_load got=%h exp=ffffffff", v); end
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    peek(2'd2, v);
    total++;
    if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL max_decrement got=%h exp=fffffffe", v); end
    tick(1'b0, 1'b1, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    tick(1'b0, 1'b1, 2'd1, 32'd50);
    tick(1'b0, 1'b1, 2'd0, 32'h9);
    for (int e = 1; e <= 12; e++) tick(1'b0, 1'b0, 2'd0, 32'd0);
    peek(2'd2, v);
    total++;
    if (v !== 32'd40) begin bad++; $display("FAIL midreset_precount got=%0d exp=40", v); end
    tick(1'b1, 1'b1, 2'd1, 32'd77);
    for (int a = 0; a < 4; a++) begin
      peek(a[1:0], v);
      total++;
      if (v !== 32'd0) begin bad++; $display("FAIL midreset_dout[%0d] got=%h exp=0", a, v); end
    end
    total++;
    if (IRQ !== 1'b0) begin bad++; $display("FAIL midreset_irq got=%b exp=0", IRQ); end
    for (int e = 0; e < 60; e++) begin
      tick(1'b0, 1'b0, 2'd0, 32'd0);
      total++;
      if (IRQ !== 1'b0) begin bad++; $display("FAIL midreset_spurious cyc=%0d got=%b exp=0", e, IRQ); end
    end
    peek(2'd2, v);
    total++;
    if (v !== 32'd0) begin bad++; $display("FAIL midreset_count_after got=%0d exp=0", v); end
  endtask

  task automatic test_random();
    logic        r;
    logic        we;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 5) == 0);
      a  = 2'($urandom_range(0, 3));
      if (a == 2'd1) d = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 200)) : 32'($urandom_range(0, 8));
      else d = $urandom;
      reset = r; WE = we; Addr = {28'($urandom), a}; Din = d;
      #1;
      exp = model_read(a);
      total++;
      if (Dout !== exp) begin bad++; $display("FAIL rand_dout i=%0d addr=%0d got=%h exp=%h", i, a, Dout, exp); end
      total++;
      if (IRQ !== (m_flag & m_ctrl[3])) begin
        bad++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, IRQ, m_flag & m_ctrl[3]);
      end
      @(posedge clk);
      model_step(r, we, a, d);
      @(negedge clk);
      reset = 1'b0; WE = 1'b0; Din = 32'd0;
    end
  endtask

  initial begin
    reset = 1'b1; WE = 1'b0; Addr = 30'd0; Din = 32'd0;
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0; m_phase = 0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_mask();
    test_disable();
    test_reg_edges();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
